// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard and stall controller for the 5-stage RV32 core.
// Decides each cycle which pipeline registers advance, hold, or load a bubble.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_id_rs1/rs2, if_id_use_rs*  source operands of the instruction in ID
//   id_ex_memread, id_ex_rd       load flag and destination of the instruction in EX
//   ex_redirect                   taken branch/jump resolved in EX
//   icache_stall, dcache_stall    cache miss stalls
//   pc_en .. mem_wb_en            stage register enables (combinational)
//   if_id_flush, id_ex_flush      load-NOP controls, override the matching enable (combinational)
//   state                         registered action class (RUN/LOAD_USE/MEM_WAIT/REDIRECT)
//   stall_cycles, flush_count     saturating performance counters
//   stall_timeout                 sticky cache-stall watchdog
module hazard_controller #(
   parameter int unsigned STALL_CNT_W = 32,
   parameter int unsigned FLUSH_CNT_W = 16,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             if_id_rs1,
   input  logic [4:0]             if_id_rs2,
   input  logic                   if_id_use_rs1,
   input  logic                   if_id_use_rs2,
   input  logic                   id_ex_memread,
   input  logic [4:0]             id_ex_rd,
   input  logic                   ex_redirect,
   input  logic                   icache_stall,
   input  logic                   dcache_stall,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_ex_en,
   output logic                   ex_mem_en,
   output logic                   mem_wb_en,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic [1:0]             state,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic [FLUSH_CNT_W-1:0] flush_count,
   output logic                   stall_timeout
);

   localparam int unsigned WAIT_W = 16;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W:0]   WAIT_TRIP = (WAIT_W+1)'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LOAD_USE = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   state_t            state_q;
   state_t            next_state;
   logic              lu;
   logic [WAIT_W-1:0] wait_cnt;

   assign state = 2'(state_q);

   // Load-use hazard; masked after a redirect because IF/ID then holds a bubble.
   assign lu = (state_q != ST_REDIRECT) && id_ex_memread && (id_ex_rd != 5'd0) &&
               ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

   // Prioritised action decision: enables, flushes and the next action class.
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      next_state  = ST_RUN;
      if (dcache_stall) begin
         // Whole pipe freezes; a pending redirect stays in EX until release.
         pc_en      = 1'b0;
         if_id_en   = 1'b0;
         id_ex_en   = 1'b0;
         ex_mem_en  = 1'b0;
         mem_wb_en  = 1'b0;
         next_state = ST_MEM_WAIT;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         next_state  = ST_REDIRECT;
      end else if (lu) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
         next_state  = ST_LOAD_USE;
      end else if (icache_stall) begin
         // ID drains downstream while a bubble enters ID.
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
         next_state  = ST_MEM_WAIT;
      end
   end

   // State register, performance counters and watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         stall_cycles  <= '0;
         flush_count   <= '0;
         wait_cnt      <= '0;
         stall_timeout <= 1'b0;
      end else begin
         state_q <= next_state;
         if (!pc_en && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
         if ((next_state == ST_REDIRECT) && (flush_count != '1))
            flush_count <= flush_count + FLUSH_CNT_W'(1);
         if (icache_stall || dcache_stall) begin
            if (wait_cnt != WAIT_MAX)
               wait_cnt <= wait_cnt + WAIT_W'(1);
            if (({1'b0, wait_cnt} + 17'd1) >= WAIT_TRIP)
               stall_timeout <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scoreboard bench for hazard_controller
// (small counter widths and TIMEOUT=4 so saturation and the watchdog are reachable).
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic       if_id_use_rs1, if_id_use_rs2, id_ex_memread;
   logic       ex_redirect, icache_stall, dcache_stall;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
   logic [1:0] state;
   logic [2:0] stall_cycles;
   logic [15:0] flush_count;
   logic       stall_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   localparam logic [6:0] EN_RUN = 7'b11111_00;
   localparam logic [6:0] EN_LU  = 7'b00111_01;
   localparam logic [6:0] EN_RED = 7'b11111_11;
   localparam logic [6:0] EN_DMW = 7'b00000_00;
   localparam logic [6:0] EN_IMW = 7'b01111_10;

   typedef struct { string tag; logic [6:0] en; } comb_t;
   typedef struct { string tag; logic [1:0] st; logic [2:0] sc; logic [15:0] fc; logic to; } reg_t;
   comb_t comb_q[$];
   reg_t  reg_q[$];

   int m_sc, m_fc, m_wc;
   logic m_to;

   hazard_controller #(.STALL_CNT_W(3), .FLUSH_CNT_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .ex_redirect(ex_redirect), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] en_vec();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_sc = 0; m_fc = 0; m_wc = 0; m_to = 1'b0;
   endtask

   // Drive one decision cycle, queue the expected response, then compare.
   task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                       input logic redir, input logic ic, input logic dc,
                       input logic [6:0] en_e, input logic [1:0] st_e);
      comb_t c;
      reg_t  r;
      if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_use_rs1 = u1; if_id_use_rs2 = u2;
      id_ex_memread = mr; id_ex_rd = rd;
      ex_redirect = redir; icache_stall = ic; dcache_stall = dc;
      comb_q.push_back('{tag: tag, en: en_e});
      if (!en_e[6]) m_sc = (m_sc == 7) ? 7 : m_sc + 1;
      if (st_e == 2'd3) m_fc++;
      if (ic || dc) begin
         if (m_wc + 1 >= 4) m_to = 1'b1;
         if (m_wc < 4) m_wc++;
      end else begin
         m_wc = 0;
      end
      reg_q.push_back('{tag: tag, st: st_e, sc: 3'(m_sc), fc: 16'(m_fc), to: m_to});
      #2;
      if (comb_q.size() == 0) chk({tag, "_comb_queue_empty"}, 1, 0);
      else begin
         c = comb_q.pop_front();
         chk({c.tag, "_en"}, 32'(en_vec()), 32'(c.en));
      end
      @(posedge clk); #1;
      if (reg_q.size() == 0) chk({tag, "_reg_queue_empty"}, 1, 0);
      else begin
         r = reg_q.pop_front();
         chk({r.tag, "_state"}, 32'(state), 32'(r.st));
         chk({r.tag, "_stall_cycles"}, 32'(stall_cycles), 32'(r.sc));
         chk({r.tag, "_flush_count"}, 32'(flush_count), 32'(r.fc));
         chk({r.tag, "_timeout"}, 32'(stall_timeout), 32'(r.to));
      end
   endtask

   task automatic idle(input string tag);
      step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, EN_RUN, 2'd0);
   endtask

   initial begin
      rst = 1'b1;
      if_id_rs1 = '0; if_id_rs2 = '0; if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0;
      id_ex_memread = 1'b0; id_ex_rd = '0;
      ex_redirect = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", 32'(en_vec()), 32'(EN_RUN));
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
      chk("rst_flush_count", 32'(flush_count), 32'd0);
      chk("rst_timeout", 32'(stall_timeout), 32'd0);
      rst = 1'b0;

      // Load-use through rs2, then bubble clears memread.
      step("lu_rs2", 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EN_LU, 2'd1);
      idle("after_lu");
      step("lu_rs1", 5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, EN_LU, 2'd1);
      step("lu_x0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, EN_RUN, 2'd0);
      step("no_use", 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EN_RUN, 2'd0);

      // Redirect, then stale load-use inputs are masked.
      step("redirect", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, EN_RED, 2'd3);
      step("lu_masked", 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, EN_RUN, 2'd0);

      // Redirect beats load-use and I-cache stall.
      step("red_over_lu_ic", 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, EN_RED, 2'd3);
      idle("run_a");

      // D-cache stall freezes a pending redirect for 3 cycles, then it executes.
      for (int i = 0; i < 3; i++)
         step($sformatf("dc_red_%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, EN_DMW, 2'd2);
      step("red_release", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, EN_RED, 2'd3);
      idle("run_b");

      // I-cache stall with load-use in the first cycle: load-use wins.
      step("ic_lu", 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, EN_LU, 2'd1);
      step("ic_only", 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, EN_IMW, 2'd2);
      idle("run_c");

      // Watchdog trips on the 4th consecutive stall; stall_cycles saturates at 7.
      for (int i = 0; i < 4; i++)
         step($sformatf("dc_wd_%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, EN_DMW, 2'd2);
      idle("wd_sticky");
      step("ic_sat", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EN_IMW, 2'd2);
      idle("run_d");

      // Asynchronous reset in the middle of a stall.
      step("dc_pre_rst", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, EN_DMW, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_stall_cycles", 32'(stall_cycles), 32'd0);
      chk("midrst_flush_count", 32'(flush_count), 32'd0);
      chk("midrst_timeout", 32'(stall_timeout), 32'd0);
      dcache_stall = 1'b0;
      #1;
      chk("midrst_en", 32'(en_vec()), 32'(EN_RUN));
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      idle("post_rst");
      step("post_rst_lu", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, EN_LU, 2'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
